// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined add/subtract unit.
// Build option: ADDSUB_SAT_EN makes accumulate overflow clamp instead of wrap.
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic {
        DST_SUM = 1'b0,
        DST_SUB = 1'b1
    } dst_e;

    localparam logic SEL_B = 1'b0;
    localparam logic SEL_C = 1'b1;

    // Low `width` bits of the result hold -2^(width-1) or 2^(width-1)-1.
    function automatic logic [63:0] sat_limit(input int width, input logic negative);
        logic [63:0] lim;
        lim = 64'd1 << (width - 1);
        if (negative) begin
            return -lim;
        end
        return lim - 64'd1;
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Operand mux plus exact N+1-bit add/subtract; purely combinational.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic signed [N-1:0] c,
    input  logic                sm,
    input  logic                sub_sel,
    output logic signed [N:0]   r
);

    logic signed [N-1:0] opnd;
    logic        [N:0]   a_ext;
    logic        [N:0]   opnd_ext;

    always_comb begin
        opnd = b;
        case (sm)
            SEL_B:   opnd = b;
            SEL_C:   opnd = c;
            default: opnd = b;
        endcase

        // One extra bit keeps the sum or difference of two N-bit values exact.
        a_ext    = {a[N-1], a};
        opnd_ext = {opnd[N-1], opnd};
        r        = '0;
        case (op_e'(sub_sel))
            OP_ADD:  r = a_ext + opnd_ext;
            OP_SUB:  r = a_ext - opnd_ext;
            default: r = a_ext + opnd_ext;
        endcase
    end

endmodule

// File: rtl/addsub_pipe.sv
// Two-cycle registered add/subtract with load/accumulate destinations and sticky overflow.
// Build option: ADDSUB_SAT_EN clamps accumulate overflow; default wraps modulo 2^W.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int N = 4,
    parameter int G = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                SM,
    input  logic                AS,
    input  logic                SD,
    input  logic                ACC,
    input  logic                clr,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic signed [N-1:0] c,
    output logic signed [N+G-1:0] Sum,
    output logic signed [N+G-1:0] Sub,
    output logic                ovf_sum,
    output logic                ovf_sub,
    output logic                out_valid,
    output logic                out_dst
);

    localparam int W = N + G;

    logic signed [N-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic                sm_q, sm_d, as_q, as_d, in_sd_q, in_sd_d, in_acc_q, in_acc_d;
    logic                cap_valid_q, cap_valid_d;

    logic signed [N:0]   core_r, r_q, r_d;
    logic                s1_sd_q, s1_sd_d, s1_acc_q, s1_acc_d, s1_valid_q, s1_valid_d;

    logic signed [W-1:0] sum_q, sum_d, sub_q, sub_d;
    logic signed [W-1:0] cur, r_ext, acc_sum, new_val;
    logic                ovf;
    logic                ovf_sum_q, ovf_sum_d, ovf_sub_q, ovf_sub_d;
    logic                out_valid_q, out_valid_d, out_dst_q, out_dst_d;
`ifdef ADDSUB_SAT_EN
    logic [63:0]         lim;
`endif

    addsub_core #(.N(N)) u_core (
        .a       (a_q),
        .b       (b_q),
        .c       (c_q),
        .sm      (sm_q),
        .sub_sel (as_q),
        .r       (core_r)
    );

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        sm_d        = sm_q;
        as_d        = as_q;
        in_sd_d     = in_sd_q;
        in_acc_d    = in_acc_q;
        cap_valid_d = in_valid;
        if (in_valid) begin
            a_d      = a;
            b_d      = b;
            c_d      = c;
            sm_d     = SM;
            as_d     = AS;
            in_sd_d  = SD;
            in_acc_d = ACC;
        end

        r_d        = r_q;
        s1_sd_d    = s1_sd_q;
        s1_acc_d   = s1_acc_q;
        s1_valid_d = cap_valid_q;
        if (cap_valid_q) begin
            r_d      = core_r;
            s1_sd_d  = in_sd_q;
            s1_acc_d = in_acc_q;
        end

        // Stage 2 reads the register it writes, so back-to-back accumulates need no bypass.
        cur     = (s1_sd_q == DST_SUM) ? sum_q : sub_q;
        r_ext   = W'(r_q);
        acc_sum = cur + r_ext;
        ovf     = s1_acc_q && (cur[W-1] == r_ext[W-1]) && (acc_sum[W-1] != cur[W-1]);
        new_val = s1_acc_q ? acc_sum : r_ext;
`ifdef ADDSUB_SAT_EN
        lim = '0;
        if (ovf) begin
            lim     = sat_limit(W, cur[W-1]);
            new_val = lim[W-1:0];
        end
`endif

        sum_d       = sum_q;
        sub_d       = sub_q;
        ovf_sum_d   = ovf_sum_q;
        ovf_sub_d   = ovf_sub_q;
        out_valid_d = s1_valid_q;
        out_dst_d   = out_dst_q;
        if (s1_valid_q) begin
            out_dst_d = s1_sd_q;
            if (s1_sd_q == DST_SUB) begin
                sub_d     = new_val;
                ovf_sub_d = ovf_sub_q | ovf;
            end else begin
                sum_d     = new_val;
                ovf_sum_d = ovf_sum_q | ovf;
            end
        end

        // Clear beats both the capture and the write happening on the same edge.
        if (clr) begin
            cap_valid_d = 1'b0;
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            sum_d       = '0;
            sub_d       = '0;
            ovf_sum_d   = 1'b0;
            ovf_sub_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            sm_q        <= 1'b0;
            as_q        <= 1'b0;
            in_sd_q     <= 1'b0;
            in_acc_q    <= 1'b0;
            cap_valid_q <= 1'b0;
            r_q         <= '0;
            s1_sd_q     <= 1'b0;
            s1_acc_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            sum_q       <= '0;
            sub_q       <= '0;
            ovf_sum_q   <= 1'b0;
            ovf_sub_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_dst_q   <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            sm_q        <= sm_d;
            as_q        <= as_d;
            in_sd_q     <= in_sd_d;
            in_acc_q    <= in_acc_d;
            cap_valid_q <= cap_valid_d;
            r_q         <= r_d;
            s1_sd_q     <= s1_sd_d;
            s1_acc_q    <= s1_acc_d;
            s1_valid_q  <= s1_valid_d;
            sum_q       <= sum_d;
            sub_q       <= sub_d;
            ovf_sum_q   <= ovf_sum_d;
            ovf_sub_q   <= ovf_sub_d;
            out_valid_q <= out_valid_d;
            out_dst_q   <= out_dst_d;
        end
    end

    assign Sum       = sum_q;
    assign Sub       = sub_q;
    assign ovf_sum   = ovf_sum_q;
    assign ovf_sub   = ovf_sub_q;
    assign out_valid = out_valid_q;
    assign out_dst   = out_dst_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (N=4, G=2): directed vectors with hand-computed results.
// Expected third-accumulate value follows ADDSUB_SAT_EN when that macro is defined.
module tb_addsub_pipe;

    localparam int N = 4;
    localparam int G = 2;
    localparam int W = N + G;

`ifdef ADDSUB_SAT_EN
    localparam int ACC_THIRD = 31;
`else
    localparam int ACC_THIRD = -19;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                sm, as_op, sd, acc, clr;
    logic signed [N-1:0] a, b, c;
    logic signed [W-1:0] sum, sub;
    logic                ovf_sum, ovf_sub, out_valid, out_dst;

    typedef struct {
        logic dst;
        int   value;
        logic ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    addsub_pipe #(.N(N), .G(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .SM        (sm),
        .AS        (as_op),
        .SD        (sd),
        .ACC       (acc),
        .clr       (clr),
        .a         (a),
        .b         (b),
        .c         (c),
        .Sum       (sum),
        .Sub       (sub),
        .ovf_sum   (ovf_sum),
        .ovf_sub   (ovf_sub),
        .out_valid (out_valid),
        .out_dst   (out_dst)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drives one transaction for a single cycle; a write expectation is queued when one is due.
    task automatic applyStimulus(input logic s_sm, input logic s_as, input logic s_sd,
                                 input logic s_acc, input int va, input int vb, input int vc,
                                 input logic expect_write, input int exp_val, input logic exp_ovf);
        exp_t e;
        in_valid = 1'b1;
        sm       = s_sm;
        as_op    = s_as;
        sd       = s_sd;
        acc      = s_acc;
        a        = N'(va);
        b        = N'(vb);
        c        = N'(vc);
        if (expect_write) begin
            e.dst   = s_sd;
            e.value = exp_val;
            e.ovf   = exp_ovf;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checkOutput("drain_queue", exp_q.size(), 0);
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_dst", int'(out_dst), int'(e.dst));
                checkOutput("dst_value", e.dst ? int'(sub) : int'(sum), e.value);
                checkOutput("dst_ovf", e.dst ? int'(ovf_sub) : int'(ovf_sum), int'(e.ovf));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        clr      = 1'b0;
        sm       = 1'b0;
        as_op    = 1'b0;
        sd       = 1'b0;
        acc      = 1'b0;
        a        = 4'sd7;
        b        = 4'sd1;
        c        = 4'sd2;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        checkOutput("reset_sum", int'(sum), 0);
        checkOutput("reset_sub", int'(sub), 0);
        checkOutput("reset_ovf_sum", int'(ovf_sum), 0);
        checkOutput("reset_ovf_sub", int'(ovf_sub), 0);
        checkOutput("reset_out_dst", int'(out_dst), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("reset_out_valid", int'(out_valid), 0);
        end

        $display("[TB] load add into Sum");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7, -8, 0, 1'b1, -1, 1'b0);
        waitDrain();
        checkOutput("load_add_sub_hold", int'(sub), 0);

        $display("[TB] load subtract via c into Sub");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, -8, 0, 7, 1'b1, -15, 1'b0);
        waitDrain();
        checkOutput("load_sub_sum_hold", int'(sum), -1);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("clr_sum", int'(sum), 0);
        checkOutput("clr_sub", int'(sub), 0);

        $display("[TB] back-to-back accumulate into Sum");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 7, -8, 0, 1'b1, 15, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 7, -8, 0, 1'b1, 30, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 7, -8, 0, 1'b1, ACC_THIRD, 1'b1);
        waitDrain();
        checkOutput("acc_ovf_sum_sticky", int'(ovf_sum), 1);
        checkOutput("acc_sub_hold", int'(sub), 0);

        $display("[TB] clr on the write edge");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 0, 1'b0, 0, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("clr_collide_sum", int'(sum), 0);
        checkOutput("clr_collide_ovf_sum", int'(ovf_sum), 0);
        checkOutput("clr_collide_out_valid", int'(out_valid), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3, 2, 0, 1'b1, 5, 1'b0);
        waitDrain();

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 1, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midreset_out_valid", int'(out_valid), 0);
        end
        checkOutput("midreset_sum", int'(sum), 0);
        checkOutput("midreset_sub", int'(sub), 0);
        checkOutput("midreset_ovf_sum", int'(ovf_sum), 0);
        checkOutput("midreset_ovf_sub", int'(ovf_sub), 0);
        checkOutput("midreset_out_dst", int'(out_dst), 0);

        checkOutput("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
